// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the memory arbiter: memory line geometry, the
//   beat-counter type, the owner encoding and a last-beat helper.
//
//   MEM_DATA_BITS / MEM_DATA_CYCLES / ceilLog2 normally come from the shared
//   riscvConst.vh / macros.vh headers. They are only defined here when the
//   build has not already provided them, so the shared values always win.
// -----------------------------------------------------------------------------
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

package mem_arbiter_pkg;

    localparam int DATA_BITS   = `MEM_DATA_BITS;
    localparam int DATA_CYCLES = `MEM_DATA_CYCLES;

    // A one-beat line still needs a 1-bit counter to keep the types legal.
    localparam int BEAT_W = (DATA_CYCLES > 1) ? `ceilLog2(DATA_CYCLES) : 1;

    typedef logic [BEAT_W-1:0] beat_t;

    // Which client owns the single outstanding memory transaction.
    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    function automatic logic is_last_beat(input beat_t cnt);
        return cnt == beat_t'(DATA_CYCLES - 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
//   Two-input picker. Client A wins when it is the only requester, or when
//   both request and prefer_a_i is set; otherwise client B wins.
//
//   Ports
//     a_val_i     : client A (dcache) requesting
//     b_val_i     : client B (icache) requesting
//     prefer_a_i  : tie-break, 1 = A wins a tie
//     pick_a_o    : A is picked (only meaningful when pick_any_o is 1)
//     pick_any_o  : at least one client is requesting
// -----------------------------------------------------------------------------
module mem_arb_pick (
    input  logic a_val_i,
    input  logic b_val_i,
    input  logic prefer_a_i,
    output logic pick_a_o,
    output logic pick_any_o
);

    assign pick_a_o   = a_val_i & (~b_val_i | prefer_a_i);
    assign pick_any_o = a_val_i | b_val_i;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between the icache (reads only) and the dcache
//   (reads and line writebacks). Exactly one memory transaction is
//   outstanding at a time; the owner register records which client it
//   belongs to so that responses are steered back to it.
//
//   Handshakes: every *_val/*_rdy pair transfers on the cycle where both are
//   high. A requester holds val (and its payload) until it sees rdy; rdy may
//   depend combinationally on val and on the downstream rdy.
//
//   Configuration macro
//     MEM_ARB_ROUND_ROBIN_EN : defined  -> client granted last loses next tie
//                              undefined-> dcache always wins a tie
//
//   Ports
//     clk, reset                       : clock, synchronous active-high reset
//     ic_req_*                         : icache read request
//     ic_resp_val/nack/data            : icache refill beats / nack
//     dc_req_* (dc_req_rw 1 = write)   : dcache request
//     dc_wdata_val/rdy, dc_wdata       : dcache writeback beats
//     dc_resp_val/nack/data            : dcache refill beats / nack
//     mem_req_*, mem_wdata*, mem_resp_*: shared memory port
//     dbg_state_o, dbg_beat_o,
//     dbg_owner_o                      : FSM state, beat counter, owner
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 28
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_req_val,
    output logic                      ic_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]  ic_req_addr,
    output logic                      ic_resp_val,
    output logic                      ic_resp_nack,
    output logic [`MEM_DATA_BITS-1:0] ic_resp_data,

    input  logic                      dc_req_val,
    output logic                      dc_req_rdy,
    input  logic [MEM_ADDR_BITS-1:0]  dc_req_addr,
    input  logic                      dc_req_rw,
    input  logic                      dc_wdata_val,
    output logic                      dc_wdata_rdy,
    input  logic [`MEM_DATA_BITS-1:0] dc_wdata,
    output logic                      dc_resp_val,
    output logic                      dc_resp_nack,
    output logic [`MEM_DATA_BITS-1:0] dc_resp_data,

    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    output logic                      mem_req_rw,
    output logic                      mem_wdata_val,
    input  logic                      mem_wdata_rdy,
    output logic [`MEM_DATA_BITS-1:0] mem_wdata,
    input  logic                      mem_resp_val,
    input  logic                      mem_resp_nack,
    input  logic [`MEM_DATA_BITS-1:0] mem_resp_data,

    output logic [1:0]                dbg_state_o,
    output logic [BEAT_W-1:0]         dbg_beat_o,
    output logic                      dbg_owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WDATA     = 2'd1,
        ST_RESP_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    state_e state_q, state_d;
    beat_t  beat_q,  beat_d;
    owner_e owner_q, owner_d;

    // Grant latch: once the memory stalls a presented request, that client
    // keeps the grant until it is accepted (or it withdraws its val).
    logic   lock_q,    lock_d;
    logic   lock_dc_q, lock_dc_d;

    logic   prefer_dc;
    logic   pick_dc, pick_any;
    logic   lock_hit;
    logic   grant_dc, grant_any;
    logic   fwd_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic   prefer_dc_q, prefer_dc_d;
    assign prefer_dc = prefer_dc_q;
`else
    assign prefer_dc = 1'b1;
`endif

    mem_arb_pick u_pick (
        .a_val_i    (dc_req_val),
        .b_val_i    (ic_req_val),
        .prefer_a_i (prefer_dc),
        .pick_a_o   (pick_dc),
        .pick_any_o (pick_any)
    );

    // The latch only counts while the latched client is still requesting.
    assign lock_hit  = lock_q & (lock_dc_q ? dc_req_val : ic_req_val);
    assign grant_dc  = lock_hit ? lock_dc_q : pick_dc;
    assign grant_any = lock_hit | pick_any;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        lock_dc_d = lock_dc_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prefer_dc_d = prefer_dc_q;
`endif

        mem_req_val   = 1'b0;
        mem_req_addr  = grant_dc ? dc_req_addr : ic_req_addr;
        mem_req_rw    = grant_dc & dc_req_rw;
        ic_req_rdy    = 1'b0;
        dc_req_rdy    = 1'b0;
        mem_wdata_val = 1'b0;
        mem_wdata     = dc_wdata;
        dc_wdata_rdy  = 1'b0;
        fwd_resp      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                mem_req_val = grant_any;
                ic_req_rdy  = grant_any & ~grant_dc & mem_req_rdy;
                dc_req_rdy  = grant_any &  grant_dc & mem_req_rdy;
                if (grant_any && mem_req_rdy) begin
                    owner_d = grant_dc ? OWN_DC : OWN_IC;
                    beat_d  = '0;
                    lock_d  = 1'b0;
                    state_d = mem_req_rw ? ST_WDATA : ST_RESP_WAIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    prefer_dc_d = ~grant_dc;
`endif
                end else if (grant_any) begin
                    lock_d    = 1'b1;
                    lock_dc_d = grant_dc;
                end else begin
                    lock_d    = 1'b0;
                end
            end

            ST_WDATA: begin
                mem_wdata_val = dc_wdata_val;
                dc_wdata_rdy  = mem_wdata_rdy;
                if (dc_wdata_val && mem_wdata_rdy) begin
                    if (is_last_beat(beat_q)) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + beat_t'(1);
                    end
                end
            end

            ST_RESP_WAIT: begin
                fwd_resp = 1'b1;
                if (mem_resp_val) begin
                    // The first data beat is beat 0 of the line.
                    if (is_last_beat(beat_t'(0))) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_t'(1);
                        state_d = ST_RESP;
                    end
                end else if (mem_resp_nack) begin
                    beat_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_RESP: begin
                fwd_resp = 1'b1;
                if (mem_resp_val) begin
                    if (is_last_beat(beat_q)) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + beat_t'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // During reset the outgoing handshakes must be quiet even though the
        // registers still hold the pre-reset transaction.
        if (reset) begin
            mem_req_val   = 1'b0;
            ic_req_rdy    = 1'b0;
            dc_req_rdy    = 1'b0;
            mem_wdata_val = 1'b0;
            dc_wdata_rdy  = 1'b0;
            fwd_resp      = 1'b0;
        end
    end

    // Responses are steered to the owner only; data is broadcast.
    assign ic_resp_val  = fwd_resp & (owner_q == OWN_IC) & mem_resp_val;
    assign ic_resp_nack = fwd_resp & (owner_q == OWN_IC) & mem_resp_nack;
    assign dc_resp_val  = fwd_resp & (owner_q == OWN_DC) & mem_resp_val;
    assign dc_resp_nack = fwd_resp & (owner_q == OWN_DC) & mem_resp_nack;
    assign ic_resp_data = mem_resp_data;
    assign dc_resp_data = mem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            owner_q   <= OWN_IC;
            lock_q    <= 1'b0;
            lock_dc_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prefer_dc_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            owner_q   <= owner_d;
            lock_q    <= lock_d;
            lock_dc_q <= lock_dc_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prefer_dc_q <= prefer_dc_d;
`endif
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_beat_o  = beat_q;
    assign dbg_owner_o = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 28;
    localparam int DW = `MEM_DATA_BITS;
    localparam int NB = `MEM_DATA_CYCLES;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic clk, reset;
    logic ic_req_val, ic_req_rdy;
    logic [AW-1:0] ic_req_addr;
    logic ic_resp_val, ic_resp_nack;
    logic [DW-1:0] ic_resp_data;
    logic dc_req_val, dc_req_rdy, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic dc_wdata_val, dc_wdata_rdy;
    logic [DW-1:0] dc_wdata;
    logic dc_resp_val, dc_resp_nack;
    logic [DW-1:0] dc_resp_data;
    logic mem_req_val, mem_req_rdy, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic mem_wdata_val, mem_wdata_rdy;
    logic [DW-1:0] mem_wdata;
    logic mem_resp_val, mem_resp_nack;
    logic [DW-1:0] mem_resp_data;
    logic [1:0] dbg_state;
    logic [BEAT_W-1:0] dbg_beat;
    logic dbg_owner;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    mem_arbiter #(.MEM_ADDR_BITS(AW)) dut (
        .clk(clk), .reset(reset),
        .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
        .ic_resp_val(ic_resp_val), .ic_resp_nack(ic_resp_nack), .ic_resp_data(ic_resp_data),
        .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
        .dc_req_rw(dc_req_rw), .dc_wdata_val(dc_wdata_val), .dc_wdata_rdy(dc_wdata_rdy),
        .dc_wdata(dc_wdata), .dc_resp_val(dc_resp_val), .dc_resp_nack(dc_resp_nack),
        .dc_resp_data(dc_resp_data),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_rw(mem_req_rw), .mem_wdata_val(mem_wdata_val), .mem_wdata_rdy(mem_wdata_rdy),
        .mem_wdata(mem_wdata), .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack),
        .mem_resp_data(mem_resp_data),
        .dbg_state_o(dbg_state), .dbg_beat_o(dbg_beat), .dbg_owner_o(dbg_owner)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Every task starts and ends just after a falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ic_req_val = 0; ic_req_addr = '0;
        dc_req_val = 0; dc_req_addr = '0; dc_req_rw = 0;
        dc_wdata_val = 0; dc_wdata = '0;
        mem_req_rdy = 0; mem_wdata_rdy = 0;
        mem_resp_val = 0; mem_resp_nack = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] beat_word(input int tag, input int b);
        return DW'(32'hC0DE_0000) | DW'(tag << 8) | DW'(b);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        ic_req_val = 1; dc_req_val = 1; mem_req_rdy = 1;
        mem_resp_val = 1; mem_resp_nack = 1; dc_wdata_val = 1; mem_wdata_rdy = 1;
        #1;
        checks++;
        if ({mem_req_val, ic_req_rdy, dc_req_rdy, mem_wdata_val, dc_wdata_rdy,
             ic_resp_val, ic_resp_nack, dc_resp_val, dc_resp_nack} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000000",
                {mem_req_val, ic_req_rdy, dc_req_rdy, mem_wdata_val, dc_wdata_rdy,
                 ic_resp_val, ic_resp_nack, dc_resp_val, dc_resp_nack});
        end
        tick();
        checks++;
        if ({dbg_state, dbg_owner} !== {S_IDLE, 1'b0} || dbg_beat !== '0) begin
            failures++;
            $display("FAIL reset_state got state=%0d owner=%0d beat=%0d exp 0/0/0",
                dbg_state, dbg_owner, dbg_beat);
        end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_ic_read();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h123; mem_req_rdy = 1;
        #1;
        checks++;
        if ({mem_req_val, mem_req_rw, ic_req_rdy, dc_req_rdy} !== 4'b1010
            || mem_req_addr !== 28'h123) begin
            failures++;
            $display("FAIL ic_read_req got val/rw/icr/dcr=%b addr=%h exp 1010 addr=123",
                {mem_req_val, mem_req_rw, ic_req_rdy, dc_req_rdy}, mem_req_addr);
        end
        tick();
        ic_req_val = 0; mem_req_rdy = 0;
        #1;
        checks++;
        if (dbg_state !== S_RWAIT || mem_req_val !== 1'b0) begin
            failures++;
            $display("FAIL ic_read_wait got state=%0d mem_req_val=%b exp 2/0", dbg_state, mem_req_val);
        end
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1; mem_resp_data = beat_word(1, b);
            #1;
            checks++;
            if ({ic_resp_val, dc_resp_val} !== 2'b10 || ic_resp_data !== beat_word(1, b)) begin
                failures++;
                $display("FAIL ic_read_beat%0d got ic/dc=%b data=%h exp 10 data=%h",
                    b, {ic_resp_val, dc_resp_val}, ic_resp_data, beat_word(1, b));
            end
            tick();
        end
        mem_resp_val = 0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || dbg_beat !== '0) begin
            failures++;
            $display("FAIL ic_read_done got state=%0d beat=%0d exp 0/0", dbg_state, dbg_beat);
        end
        // stray response while idle must not reach either client
        mem_resp_val = 1; mem_resp_nack = 1;
        #1;
        checks++;
        if ({ic_resp_val, ic_resp_nack, dc_resp_val, dc_resp_nack} !== 4'b0) begin
            failures++;
            $display("FAIL idle_resp_ignored got=%b exp=0000",
                {ic_resp_val, ic_resp_nack, dc_resp_val, dc_resp_nack});
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h200;
        dc_req_val = 1; dc_req_addr = 28'h300; mem_req_rdy = 1;
        #1;
        checks++;
        if ({ic_req_rdy, dc_req_rdy} !== 2'b01 || mem_req_addr !== 28'h300) begin
            failures++;
            $display("FAIL tie_grant got icr/dcr=%b addr=%h exp 01 addr=300",
                {ic_req_rdy, dc_req_rdy}, mem_req_addr);
        end
        tick();
        dc_req_val = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1; mem_resp_data = beat_word(2, b);
            #1;
            checks++;
            if ({ic_req_rdy, mem_req_val, dc_resp_val, ic_resp_val} !== 4'b0010) begin
                failures++;
                $display("FAIL dc_owns_beat%0d got icr/mval/dcv/icv=%b exp 0010", b,
                    {ic_req_rdy, mem_req_val, dc_resp_val, ic_resp_val});
            end
            tick();
        end
        mem_resp_val = 0;
        #1;
        checks++;
        if ({ic_req_rdy, mem_req_val} !== 2'b11 || mem_req_addr !== 28'h200) begin
            failures++;
            $display("FAIL ic_after_dc got icr/mval=%b addr=%h exp 11 addr=200",
                {ic_req_rdy, mem_req_val}, mem_req_addr);
        end
        tick();
        ic_req_val = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1;
            #1;
            checks++;
            if ({ic_resp_val, dc_resp_val} !== 2'b10) begin
                failures++;
                $display("FAIL ic_second_beat%0d got ic/dc=%b exp 10", b, {ic_resp_val, dc_resp_val});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic exp_dc;
        do_reset();
        ic_req_val = 1; dc_req_val = 1; mem_req_rdy = 1;
        for (int r = 0; r < 4; r++) begin
            ic_req_addr = AW'(32'h10 + r); dc_req_addr = AW'(32'h20 + r);
            exp_dc = RR ? (r % 2 == 0) : 1'b1;
            #1;
            checks++;
            if ({dc_req_rdy, ic_req_rdy} !== {exp_dc, ~exp_dc}) begin
                failures++;
                $display("FAIL b2b_grant%0d got dcr/icr=%b exp %b", r,
                    {dc_req_rdy, ic_req_rdy}, {exp_dc, ~exp_dc});
            end
            tick();
            for (int b = 0; b < NB; b++) begin
                mem_resp_val = 1;
                #1;
                checks++;
                if ({dc_resp_val, ic_resp_val} !== {exp_dc, ~exp_dc}) begin
                    failures++;
                    $display("FAIL b2b_owner%0d_beat%0d got dcv/icv=%b exp %b", r, b,
                        {dc_resp_val, ic_resp_val}, {exp_dc, ~exp_dc});
                end
                tick();
            end
            mem_resp_val = 0;
        end
        clear_inputs();
    endtask

    task automatic test_grant_latch();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h77; mem_req_rdy = 0;
        #1;
        tick();
        dc_req_val = 1; dc_req_addr = 28'h88;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({mem_req_val, ic_req_rdy, dc_req_rdy} !== 3'b100 || mem_req_addr !== 28'h77) begin
                failures++;
                $display("FAIL latch_hold%0d got val/icr/dcr=%b addr=%h exp 100 addr=77", c,
                    {mem_req_val, ic_req_rdy, dc_req_rdy}, mem_req_addr);
            end
            tick();
        end
        mem_req_rdy = 1;
        #1;
        checks++;
        if ({ic_req_rdy, dc_req_rdy} !== 2'b10) begin
            failures++;
            $display("FAIL latch_accept got icr/dcr=%b exp 10", {ic_req_rdy, dc_req_rdy});
        end
        tick();
        checks++;
        if (dbg_owner !== 1'b0 || dbg_state !== S_RWAIT) begin
            failures++;
            $display("FAIL latch_owner got owner=%0d state=%0d exp 0/2", dbg_owner, dbg_state);
        end
        clear_inputs();
    endtask

    task automatic test_dc_write();
        int cyc, got;
        logic rdy_exp;
        logic [DW-1:0] exp_w;
        do_reset();
        dc_req_val = 1; dc_req_rw = 1; dc_req_addr = 28'h40; mem_req_rdy = 1;
        #1;
        checks++;
        if ({mem_req_val, mem_req_rw, dc_req_rdy} !== 3'b111 || mem_req_addr !== 28'h40) begin
            failures++;
            $display("FAIL wr_req got val/rw/dcr=%b addr=%h exp 111 addr=40",
                {mem_req_val, mem_req_rw, dc_req_rdy}, mem_req_addr);
        end
        tick();
        dc_req_val = 0; mem_req_rdy = 0;
        for (int k = 0; k < NB; k++) exp_q.push_back(beat_word(9, k));
        cyc = 0; got = 0;
        while (got < NB && cyc < 40) begin
            rdy_exp = (cyc % 2 == 0);
            dc_wdata_val = 1; dc_wdata = beat_word(9, got);
            mem_wdata_rdy = rdy_exp;
            mem_resp_val = 1; mem_resp_nack = 1;
            #1;
            checks++;
            if ({mem_wdata_val, dc_wdata_rdy, dc_resp_val, dc_resp_nack, ic_resp_val}
                !== {1'b1, rdy_exp, 3'b000}) begin
                failures++;
                $display("FAIL wr_cycle%0d got wv/wr/dcv/dcn/icv=%b exp %b", cyc,
                    {mem_wdata_val, dc_wdata_rdy, dc_resp_val, dc_resp_nack, ic_resp_val},
                    {1'b1, rdy_exp, 3'b000});
            end
            if (mem_wdata_val && mem_wdata_rdy && exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (mem_wdata !== exp_w) begin
                    failures++;
                    $display("FAIL wr_data%0d got=%h exp=%h", got, mem_wdata, exp_w);
                end
                got++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (got != NB || cyc != 2 * NB - 1) begin
            failures++;
            $display("FAIL wr_beats got beats=%0d cycles=%0d exp %0d/%0d", got, cyc, NB, 2 * NB - 1);
        end
        #1;
        checks++;
        if (dbg_state !== S_IDLE || {mem_wdata_val, dc_wdata_rdy} !== 2'b00) begin
            failures++;
            $display("FAIL wr_done got state=%0d wv/wr=%b exp 0/00", dbg_state,
                {mem_wdata_val, dc_wdata_rdy});
        end
        exp_q.delete();
        clear_inputs();
    endtask

    task automatic test_nack();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h55; mem_req_rdy = 1;
        tick();
        mem_resp_nack = 1;
        #1;
        checks++;
        if ({ic_resp_nack, dc_resp_nack, ic_resp_val, ic_req_rdy} !== 4'b1000) begin
            failures++;
            $display("FAIL nack_fwd got icn/dcn/icv/icr=%b exp 1000",
                {ic_resp_nack, dc_resp_nack, ic_resp_val, ic_req_rdy});
        end
        tick();
        mem_resp_nack = 0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || {mem_req_val, ic_req_rdy} !== 2'b11 || mem_req_addr !== 28'h55) begin
            failures++;
            $display("FAIL nack_retry got state=%0d val/icr=%b addr=%h exp 0/11 addr=55",
                dbg_state, {mem_req_val, ic_req_rdy}, mem_req_addr);
        end
        tick();
        ic_req_val = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1; mem_resp_data = beat_word(5, b);
            #1;
            checks++;
            if (ic_resp_val !== 1'b1 || ic_resp_data !== beat_word(5, b)) begin
                failures++;
                $display("FAIL nack_redo_beat%0d got icv=%b data=%h exp 1 data=%h", b,
                    ic_resp_val, ic_resp_data, beat_word(5, b));
            end
            tick();
        end
        mem_resp_val = 0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL nack_redo_done got state=%0d exp 0", dbg_state);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ic_req_val = 1; ic_req_addr = 28'h99; mem_req_rdy = 1;
        tick();
        ic_req_val = 0;
        for (int b = 0; b < 2; b++) begin
            mem_resp_val = 1;
            tick();
        end
        #1;
        checks++;
        if (dbg_state !== S_RESP || dbg_beat !== BEAT_W'(2)) begin
            failures++;
            $display("FAIL mid_before got state=%0d beat=%0d exp 3/2", dbg_state, dbg_beat);
        end
        reset = 1; mem_resp_val = 1;
        #1;
        checks++;
        if ({ic_resp_val, ic_resp_nack, mem_req_val} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_quiet got icv/icn/mval=%b exp 000",
                {ic_resp_val, ic_resp_nack, mem_req_val});
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE || dbg_beat !== '0 || ic_resp_val !== 1'b0) begin
            failures++;
            $display("FAIL mid_after got state=%0d beat=%0d icv=%b exp 0/0/0",
                dbg_state, dbg_beat, ic_resp_val);
        end
        tick();
        mem_resp_val = 0;
        dc_req_val = 1; dc_req_addr = 28'hABC;
        #1;
        checks++;
        if (dc_req_rdy !== 1'b1 || mem_req_addr !== 28'hABC) begin
            failures++;
            $display("FAIL mid_fresh_req got dcr=%b addr=%h exp 1 addr=abc", dc_req_rdy, mem_req_addr);
        end
        tick();
        dc_req_val = 0;
        for (int b = 0; b < NB; b++) begin
            mem_resp_val = 1;
            #1;
            checks++;
            if ({dc_resp_val, ic_resp_val} !== 2'b10) begin
                failures++;
                $display("FAIL mid_fresh_beat%0d got dcv/icv=%b exp 10", b, {dc_resp_val, ic_resp_val});
            end
            tick();
        end
        mem_resp_val = 0;
        #1;
        checks++;
        if (dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL mid_fresh_done got state=%0d exp 0", dbg_state);
        end
        clear_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_ic_read();
        test_priority();
        test_back_to_back();
        test_grant_latch();
        test_dc_write();
        test_nack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_BITS, default 28, meaning line-beat address width (WORD_ADDR_BITS minus ceilLog2(`MEM_DATA_BITS/CPU_WIDTH)).
REQ-002 SHALL have ports clk in 1 clock; reset in 1 synchronous active-high reset; one clock only.
REQ-003 SHALL have ic_req_val in 1, ic_req_rdy out 1, ic_req_addr in MEM_ADDR_BITS: icache read request.
REQ-004 SHALL have ic_resp_val out 1, ic_resp_nack out 1, ic_resp_data out `MEM_DATA_BITS: icache refill beats.
REQ-005 SHALL have dc_req_val in 1, dc_req_rdy out 1, dc_req_addr in MEM_ADDR_BITS, dc_req_rw in 1 (1=write): dcache request.
REQ-006 SHALL have dc_wdata_val in 1, dc_wdata_rdy out 1, dc_wdata in `MEM_DATA_BITS: dcache writeback beats.
REQ-007 SHALL have dc_resp_val out 1, dc_resp_nack out 1, dc_resp_data out `MEM_DATA_BITS: dcache refill beats.
REQ-008 SHALL have mem_req_val out 1, mem_req_rdy in 1, mem_req_addr out MEM_ADDR_BITS, mem_req_rw out 1, mem_wdata_val out 1, mem_wdata_rdy in 1, mem_wdata out `MEM_DATA_BITS, mem_resp_val in 1, mem_resp_nack in 1, mem_resp_data in `MEM_DATA_BITS: shared memory port.

Function
REQ-009 SHALL allow one outstanding memory transaction; owner register (IC/DC) records the granted client.
REQ-010 SHALL implement states IDLE, WDATA, RESP_WAIT, RESP.
REQ-011 IDLE: grant chosen among valid clients combinationally; mem_req_val = granted client's val; addr/rw muxed from grantee; grantee's req_rdy = mem_req_rdy; non-grantee's req_rdy = 0.
REQ-012 IDLE on mem_req_val&mem_req_rdy: owner <= grantee; rw=1 -> WDATA, rw=0 -> RESP_WAIT.
REQ-013 WDATA: mem_wdata_val=dc_wdata_val, mem_wdata=dc_wdata, dc_wdata_rdy=mem_wdata_rdy; beat counter increments per accepted beat; after `MEM_DATA_CYCLES beats -> IDLE; writes get no response and no nack.
REQ-014 RESP_WAIT: mem_resp_val -> RESP (beat counted as beat 0); mem_resp_nack -> IDLE; otherwise hold.
REQ-015 RESP: count beats; on last beat (count == `MEM_DATA_CYCLES-1 with mem_resp_val) -> IDLE, counter wraps to 0.
REQ-016 mem_resp_val/mem_resp_nack/mem_resp_data SHALL forward combinationally (zero latency) to owner's resp_val/resp_nack only; non-owner's resp_val/nack = 0; resp_data may broadcast to both.
REQ-017 In WDATA/RESP_WAIT/RESP: mem_req_val=0, ic_req_rdy=dc_req_rdy=0.
REQ-018 Outside WDATA: mem_wdata_val=0, dc_wdata_rdy=0.
REQ-019 Nacked client SHALL re-arbitrate normally from IDLE; no sticky retry grant.
REQ-020 mem_resp_val/nack in IDLE or WDATA SHALL be ignored (not forwarded).
REQ-021 Grant SHALL be stable while a client's val is held and mem_req_rdy=0 (grant latched at first unaccepted cycle until accept).

Reset
REQ-022 reset SHALL force state IDLE, beat counter 0, owner IC, grant latch clear, round-robin pointer to DC-first; all rdy/val/nack outputs 0 during reset cycle; reset mid-transaction abandons it.

Configuration
REQ-023 With MEM_ARB_ROUND_ROBIN_EN defined, priority SHALL alternate: client granted last loses the next tie.
REQ-024 Without MEM_ARB_ROUND_ROBIN_EN, dcache SHALL have fixed priority over icache on tie.

Structure
REQ-025 `MEM_DATA_BITS, `MEM_DATA_CYCLES, `ceilLog2 SHALL come from shared riscvConst.vh/macros.vh; state encodings as localparams in module.
REQ-026 Single sub-module mem_arb_pick (2-input priority/round-robin picker) is natural; all else inline.

Verification
REQ-027 IC read alone, addr 0x123, mem_req_rdy=1, 4 resp beats -> mem_req_addr=0x123, rw=0, ic_resp_val 4 cycles, dc_resp_val 0, state IDLE after beat 4.
REQ-028 IC and DC read same cycle, fixed priority -> DC granted, ic_req_rdy=0 until DC's last beat; then IC granted next cycle.
REQ-029 RR build, back-to-back simultaneous requests x4 -> grants DC,IC,DC,IC.
REQ-030 DC write addr 0x40, mem_wdata_rdy toggling 1,0,1,... -> exactly `MEM_DATA_CYCLES beats pass, data order preserved, no resp forwarded.
REQ-031 IC read nacked in RESP_WAIT -> ic_resp_nack 1 cycle, IDLE next cycle, IC re-request granted and completes.
REQ-032 reset asserted during RESP beat 2 -> next cycle IDLE, counter 0, later beats ignored, fresh request completes normally.
